instr_field_decode: RTL and testbench
=====================================

# instr_field_decode

Decode-stage front end for the ARMv8 (LEGv8 subset) pipeline. Accepts fetched instructions over a valid/ready handshake, classifies each by format (R, I, D, B, CB, IW), and splits it into register numbers, opcode and a sign/zero-extended immediate. Results are registered in a 2-entry skid buffer so fetch can be stalled without losing data. Sits between the fetch stage and the register file / control unit.

## Interface
- `DATA_W`, 64: width of extended immediate and carried PC.
- `INSTR_W`, 32: instruction width; only 32 is legal (elaboration error otherwise).
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: discard all buffered entries (branch mispredict).
- `in_valid` in 1: fetch presents an instruction.
- `in_ready` out 1: buffer can accept this cycle.
- `in_instr` in INSTR_W: instruction word.
- `in_pc` in DATA_W: instruction address.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: downstream accepts head entry.
- `out_pc` out DATA_W: PC of head entry.
- `out_opcode` out 11: instr[31:21].
- `out_fmt` out 3: 0=R,1=I,2=D,3=B,4=CB,5=IW,7=unknown.
- `out_rm` out 5: instr[20:16]; `out_rn` out 5: instr[9:5]; `out_rd` out 5: instr[4:0] (Rt for D/CB).
- `out_shamt` out 6: instr[15:10].
- `out_imm` out DATA_W: extended immediate per format.
- `out_illegal` out 1: opcode unrecognised (see Configuration).

## Operation
- Classification on 11-bit opcode: B 0x0A0–0x0BF, BL 0x4A0–0x4BF; CB 0x5A0–0x5AF; I 0x488–0x489, 0x490–0x491, 0x588–0x589, 0x590–0x591, 0x688–0x689, 0x690–0x691, 0x788–0x789; IW 0x694–0x697, 0x794–0x797; D 0x7C0, 0x7C2, 0x1C0, 0x1C2, 0x3C0, 0x3C2, 0x5C0, 0x5C2; R 0x450, 0x458, 0x550, 0x558, 0x650, 0x658, 0x69A, 0x69B, 0x6B0, 0x750, 0x758, 0x4D8; else fmt=7.
- Immediates: I = zero-extend instr[21:10]; D = sign-extend instr[20:12]; B = sign-extend instr[25:0] shifted left 2; CB = sign-extend instr[23:5] shifted left 2; IW = zero-extend instr[20:5] shifted left 16×instr[22:21]; R and unknown = 0.
- Decode is combinational on the input; decoded fields, not raw words, are stored.
- Buffer: entries HEAD and SKID, count 0..2. States EMPTY (0), ONE (1), FULL (2).
  - `in_ready` = count<2 (registered, no combinational path from `out_ready`).
  - Push when `in_valid & in_ready`; pop when `out_valid & out_ready`.
  - EMPTY: push → ONE (into HEAD).
  - ONE: push only → FULL (into SKID); pop only → EMPTY; push+pop → ONE, HEAD gets new entry.
  - FULL: pop → ONE, SKID moves to HEAD; push impossible.
- `flush` has priority over push/pop: count→0 next cycle; concurrent input is dropped.
- `rst` and `flush` both mid-transfer: reset dominates; same result.

## Timing
- Latency 1 cycle: instruction accepted at edge N is on outputs after edge N with `out_valid`=1.
- Throughput 1/cycle while `out_ready`=1.
- Outputs stable while `out_valid & ~out_ready`.
- Reset values: `out_valid`=0, `in_ready`=1 from first cycle after reset, all data outputs 0, `out_fmt`=0, `out_illegal`=0.
- After `flush`: `out_valid`=0, `in_ready`=1 next cycle.

## Configuration
- `INSTR_ILLEGAL_DETECT_EN`: when defined, `out_illegal`=1 for fmt=7 entries, and such entries still flow through the buffer. When undefined, `out_illegal` is tied 0 and fmt=7 entries are decoded as R format (fmt=0).

## Test plan
- Reset then push ADD X3,X1,X2 (0x8B020023) with `out_ready`=1 → next cycle out_valid=1, opcode 0x458, fmt 0, rm 2, rn 1, rd 3.
- LDUR X9,[X10,#-8] (0xF85F8149) → fmt 2, imm 0xFFFF_FFFF_FFFF_FFF8, rn 10, rd 9.
- B −4 (0x17FFFFFF) → fmt 3, imm 0xFFFF_FFFF_FFFF_FFFC; MOVZ X1,#0x1234,LSL16 (0xD2A24681) → fmt 5, imm 0x1234_0000.
- Hold `out_ready`=0, push 3 instructions back-to-back → in_ready drops after 2nd; 3rd held by fetch; release → all 3 out in order, none lost or duplicated.
- Two entries buffered, assert `flush` with `in_valid`=1 → next cycle out_valid=0, in_ready=1, dropped input never appears.
- Opcode 0x000 with macro defined → fmt 7, out_illegal=1; undefined → fmt 0, out_illegal=0.

Source files
------------

// File: rtl/instr_field_decode_if.sv
// Fetch-to-decode handshake and decoded-field bus for instr_field_decode.
// master drives instructions and consumes decoded entries; slave is the decoder.
interface instr_field_decode_if #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned INSTR_W = 32
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [DATA_W-1:0]  in_pc;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_pc;
  logic [10:0]        out_opcode;
  logic [2:0]         out_fmt;
  logic [4:0]         out_rm;
  logic [4:0]         out_rn;
  logic [4:0]         out_rd;
  logic [5:0]         out_shamt;
  logic [DATA_W-1:0]  out_imm;
  logic               out_illegal;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_fmt, out_rm, out_rn,
           out_rd, out_shamt, out_imm, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_fmt, out_rm, out_rn,
           out_rd, out_shamt, out_imm, out_illegal
  );
endinterface

// File: rtl/instr_field_decode.sv
// LEGv8 decode front end: format classification, field split, immediate extension, 2-entry skid buffer.
// Optional macro INSTR_ILLEGAL_DETECT_EN flags unrecognised opcodes instead of decoding them as R format.
module instr_field_decode #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned INSTR_W = 32
) (
  input logic                clk,
  input logic                rst,
  instr_field_decode_if.slave bus
);
  localparam int unsigned OPC_W   = 11;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned SHAMT_W = 6;
  localparam int unsigned FMT_W   = 3;

  localparam logic [FMT_W-1:0] FMT_R   = 3'd0;
  localparam logic [FMT_W-1:0] FMT_I   = 3'd1;
  localparam logic [FMT_W-1:0] FMT_D   = 3'd2;
  localparam logic [FMT_W-1:0] FMT_B   = 3'd3;
  localparam logic [FMT_W-1:0] FMT_CB  = 3'd4;
  localparam logic [FMT_W-1:0] FMT_IW  = 3'd5;
  localparam logic [FMT_W-1:0] FMT_UNK = 3'd7;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  if (INSTR_W != 32) begin : g_bad_instr_w
    $error("instr_field_decode: INSTR_W must be 32");
  end

  typedef struct packed {
    logic [DATA_W-1:0]  pc;
    logic [OPC_W-1:0]   opcode;
    logic [FMT_W-1:0]   fmt;
    logic [REG_W-1:0]   rm;
    logic [REG_W-1:0]   rn;
    logic [REG_W-1:0]   rd;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  imm;
    logic               illegal;
  } entry_t;

  logic [OPC_W-1:0]  opc_c;
  logic [FMT_W-1:0]  fmt_raw_c;
  logic [DATA_W-1:0] imm_c;
  entry_t            dec_c;

  logic [1:0] state_q, state_nx;
  entry_t     head_q, head_nx;
  entry_t     skid_q, skid_nx;
  logic       in_ready_q;
  logic       out_valid_q;
  logic       push_c, pop_c;

  assign opc_c = bus.in_instr[31:21];

  // Format classification on the 11-bit opcode field
  always_comb begin
    fmt_raw_c = FMT_UNK;
    case (opc_c) inside
      [11'h0A0:11'h0BF], [11'h4A0:11'h4BF]: fmt_raw_c = FMT_B;
      [11'h5A0:11'h5AF]:                    fmt_raw_c = FMT_CB;
      [11'h488:11'h489], [11'h490:11'h491],
      [11'h588:11'h589], [11'h590:11'h591],
      [11'h688:11'h689], [11'h690:11'h691],
      [11'h788:11'h789]:                    fmt_raw_c = FMT_I;
      [11'h694:11'h697], [11'h794:11'h797]: fmt_raw_c = FMT_IW;
      11'h7C0, 11'h7C2, 11'h1C0, 11'h1C2,
      11'h3C0, 11'h3C2, 11'h5C0, 11'h5C2:   fmt_raw_c = FMT_D;
      11'h450, 11'h458, 11'h550, 11'h558,
      11'h650, 11'h658, 11'h69A, 11'h69B,
      11'h6B0, 11'h750, 11'h758, 11'h4D8:   fmt_raw_c = FMT_R;
      default:                              fmt_raw_c = FMT_UNK;
    endcase
  end

  // Immediate extraction; branch offsets are word offsets, hence the <<2
  always_comb begin
    imm_c = '0;
    case (fmt_raw_c)
      FMT_I:   imm_c = DATA_W'(bus.in_instr[21:10]);
      FMT_D:   imm_c = {{(DATA_W-9){bus.in_instr[20]}}, bus.in_instr[20:12]};
      FMT_B:   imm_c = {{(DATA_W-28){bus.in_instr[25]}}, bus.in_instr[25:0], 2'b00};
      FMT_CB:  imm_c = {{(DATA_W-21){bus.in_instr[23]}}, bus.in_instr[23:5], 2'b00};
      FMT_IW:  imm_c = DATA_W'(bus.in_instr[20:5]) << {bus.in_instr[22:21], 4'b0000};
      default: imm_c = '0;
    endcase
  end

  always_comb begin
    dec_c        = '0;
    dec_c.pc     = bus.in_pc;
    dec_c.opcode = opc_c;
    dec_c.rm     = bus.in_instr[20:16];
    dec_c.rn     = bus.in_instr[9:5];
    dec_c.rd     = bus.in_instr[4:0];
    dec_c.shamt  = bus.in_instr[15:10];
    dec_c.imm    = imm_c;
`ifdef INSTR_ILLEGAL_DETECT_EN
    dec_c.fmt     = fmt_raw_c;
    dec_c.illegal = (fmt_raw_c == FMT_UNK);
`else
    dec_c.fmt     = (fmt_raw_c == FMT_UNK) ? FMT_R : fmt_raw_c;
    dec_c.illegal = 1'b0;
`endif
  end

  assign push_c = bus.in_valid & in_ready_q;
  assign pop_c  = out_valid_q & bus.out_ready;

  // Buffer occupancy FSM; flush overrides any push/pop in the same cycle
  always_comb begin
    state_nx = state_q;
    head_nx  = head_q;
    skid_nx  = skid_q;
    if (bus.flush) begin
      state_nx = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push_c) begin
            head_nx  = dec_c;
            state_nx = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push_c && pop_c) begin
            head_nx = dec_c;
          end else if (push_c) begin
            skid_nx  = dec_c;
            state_nx = ST_FULL;
          end else if (pop_c) begin
            state_nx = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop_c) begin
            head_nx  = skid_q;
            state_nx = ST_ONE;
          end
        end
        default: state_nx = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_nx;
      head_q      <= head_nx;
      skid_q      <= skid_nx;
      in_ready_q  <= (state_nx != ST_FULL);
      out_valid_q <= (state_nx != ST_EMPTY);
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_pc      = head_q.pc;
  assign bus.out_opcode  = head_q.opcode;
  assign bus.out_fmt     = head_q.fmt;
  assign bus.out_rm      = head_q.rm;
  assign bus.out_rn      = head_q.rn;
  assign bus.out_rd      = head_q.rd;
  assign bus.out_shamt   = head_q.shamt;
  assign bus.out_imm     = head_q.imm;
  assign bus.out_illegal = head_q.illegal;
endmodule

// File: tb/tb_instr_field_decode.sv
// Directed plus randomized bench for instr_field_decode against a queue-based reference model.
module tb_instr_field_decode;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  instr_field_decode_if #(.DATA_W(64), .INSTR_W(32)) bus ();

  instr_field_decode #(.DATA_W(64), .INSTR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] pc;
    logic [10:0] op;
    logic [2:0]  fmt;
    logic [4:0]  rm;
    logic [4:0]  rn;
    logic [4:0]  rd;
    logic [5:0]  shamt;
    logic [63:0] imm;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  int i_ops[14] = '{'h488, 'h489, 'h490, 'h491, 'h588, 'h589, 'h590,
                    'h591, 'h688, 'h689, 'h690, 'h691, 'h788, 'h789};
  int d_ops[8]  = '{'h7C0, 'h7C2, 'h1C0, 'h1C2, 'h3C0, 'h3C2, 'h5C0, 'h5C2};
  int r_ops[12] = '{'h450, 'h458, 'h550, 'h558, 'h650, 'h658,
                    'h69A, 'h69B, 'h6B0, 'h750, 'h758, 'h4D8};
  int pool[20]  = '{'h0A0, 'h0BF, 'h4A0, 'h4BF, 'h5A0, 'h5AF, 'h488, 'h591, 'h789, 'h694,
                    'h797, 'h7C0, 'h3C2, 'h1C0, 'h450, 'h69B, 'h4D8, 'h6B0, 'h000, 'h7FF};

  function automatic exp_t ref_decode(input logic [31:0] w, input logic [63:0] pc);
    exp_t   r;
    int     opc;
    int     f;
    longint v;
    opc = int'(w >> 21);
    f = 7;
    if ((opc >= 'h0A0 && opc <= 'h0BF) || (opc >= 'h4A0 && opc <= 'h4BF)) f = 3;
    else if (opc >= 'h5A0 && opc <= 'h5AF) f = 4;
    else if ((opc >= 'h694 && opc <= 'h697) || (opc >= 'h794 && opc <= 'h797)) f = 5;
    else begin
      foreach (i_ops[k]) if (i_ops[k] == opc) f = 1;
      foreach (d_ops[k]) if (d_ops[k] == opc) f = 2;
      foreach (r_ops[k]) if (r_ops[k] == opc) f = 0;
    end
    r.ill = (f == 7);
`ifndef INSTR_ILLEGAL_DETECT_EN
    if (f == 7) f = 0;
    r.ill = 1'b0;
`endif
    case (f)
      1: v = longint'((w >> 10) & 32'hFFF);
      2: begin
        v = longint'((w >> 12) & 32'h1FF);
        if (v >= 256) v = v - 512;
      end
      3: begin
        v = longint'(w & 32'h3FF_FFFF);
        if (v >= 64'sd33554432) v = v - 64'sd67108864;
        v = v * 4;
      end
      4: begin
        v = longint'((w >> 5) & 32'h7FFFF);
        if (v >= 262144) v = v - 524288;
        v = v * 4;
      end
      5: v = longint'((w >> 5) & 32'hFFFF) << (16 * int'((w >> 21) & 32'h3));
      default: v = 0;
    endcase
    r.pc    = pc;
    r.op    = 11'(opc);
    r.fmt   = 3'(f);
    r.rm    = 5'(w >> 16);
    r.rn    = 5'(w >> 5);
    r.rd    = 5'(w);
    r.shamt = 6'(w >> 10);
    r.imm   = 64'(v);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
    if (q.size() > 0) begin
      e = q[0];
      chk("out_pc", bus.out_pc, e.pc);
      chk("out_opcode", 64'(bus.out_opcode), 64'(e.op));
      chk("out_fmt", 64'(bus.out_fmt), 64'(e.fmt));
      chk("out_rm", 64'(bus.out_rm), 64'(e.rm));
      chk("out_rn", 64'(bus.out_rn), 64'(e.rn));
      chk("out_rd", 64'(bus.out_rd), 64'(e.rd));
      chk("out_shamt", 64'(bus.out_shamt), 64'(e.shamt));
      chk("out_imm", bus.out_imm, e.imm);
      chk("out_illegal", 64'(bus.out_illegal), 64'(e.ill));
    end
  endtask

  // One clock: drive, advance the model at the edge, check at the falling edge
  task automatic step(input logic v, input logic [31:0] w, input logic [63:0] pc,
                      input logic ordy, input logic fl, output logic acc);
    int sz;
    bus.in_valid  = v;
    bus.in_instr  = w;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    bus.flush     = fl;
    @(posedge clk);
    sz  = q.size();
    acc = fl ? v : (v && sz < 2);
    if (fl) q.delete();
    else begin
      if (ordy && sz > 0) void'(q.pop_front());
      if (v && sz < 2) q.push_back(ref_decode(w, pc));
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    logic        acc;
    logic [31:0] w;
    logic [31:0] arr[3];
    logic [63:0] pc;
    logic        pend;
    int          idx;

    rst = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_instr = '0;
    bus.in_pc = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    chk("rst_pc", bus.out_pc, 64'h0);
    chk("rst_opcode", 64'(bus.out_opcode), 64'h0);
    chk("rst_fmt", 64'(bus.out_fmt), 64'h0);
    chk("rst_imm", bus.out_imm, 64'h0);
    chk("rst_illegal", 64'(bus.out_illegal), 64'h0);
    rst = 1'b0;

    step(1'b1, 32'h8B020023, 64'h1000, 1'b1, 1'b0, acc);
    chk("add_opcode", 64'(bus.out_opcode), 64'h458);
    chk("add_fmt", 64'(bus.out_fmt), 64'h0);
    chk("add_rm", 64'(bus.out_rm), 64'd2);
    chk("add_rn", 64'(bus.out_rn), 64'd1);
    chk("add_rd", 64'(bus.out_rd), 64'd3);
    step(1'b1, 32'hF85F8149, 64'h1004, 1'b1, 1'b0, acc);
    chk("ldur_fmt", 64'(bus.out_fmt), 64'd2);
    chk("ldur_imm", bus.out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("ldur_rn", 64'(bus.out_rn), 64'd10);
    chk("ldur_rd", 64'(bus.out_rd), 64'd9);
    step(1'b1, 32'h17FFFFFF, 64'h1008, 1'b1, 1'b0, acc);
    chk("b_fmt", 64'(bus.out_fmt), 64'd3);
    chk("b_imm", bus.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b1, 32'hD2A24681, 64'h100C, 1'b1, 1'b0, acc);
    chk("movz_fmt", 64'(bus.out_fmt), 64'd5);
    chk("movz_imm", bus.out_imm, 64'h0000_0000_1234_0000);
    step(1'b1, 32'h001FFFFF, 64'h1010, 1'b1, 1'b0, acc);
`ifdef INSTR_ILLEGAL_DETECT_EN
    chk("unk_fmt", 64'(bus.out_fmt), 64'd7);
    chk("unk_illegal", 64'(bus.out_illegal), 64'd1);
`else
    chk("unk_fmt", 64'(bus.out_fmt), 64'd0);
    chk("unk_illegal", 64'(bus.out_illegal), 64'd0);
`endif
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);

    // Stall: three back-to-back instructions with downstream blocked, then released
    arr[0] = 32'h8B020023; arr[1] = 32'hF85F8149; arr[2] = 32'hB4000041;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      step(idx < 3, arr[idx % 3], 64'h2000 + 64'(idx * 4), c >= 4, 1'b0, acc);
      if (acc && idx < 3) idx++;
      if (c == 1) chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    end
    chk("stall_all_sent", 64'(idx), 64'd3);
    chk("stall_drained", 64'(bus.out_valid), 64'd0);

    // Flush with two buffered entries and a concurrent input
    step(1'b1, 32'h91000421, 64'h3000, 1'b0, 1'b0, acc);
    step(1'b1, 32'hCB030041, 64'h3004, 1'b0, 1'b0, acc);
    step(1'b1, 32'h8B050083, 64'h3008, 1'b1, 1'b1, acc);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);

    // Reset and flush together while full: reset clears data outputs too
    step(1'b1, 32'h91000421, 64'h4000, 1'b0, 1'b0, acc);
    step(1'b1, 32'hCB030041, 64'h4004, 1'b0, 1'b0, acc);
    rst = 1'b1; bus.flush = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk);
    q.delete();
    @(negedge clk);
    rst = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0;
    check_outputs();
    chk("rst_flush_pc", bus.out_pc, 64'h0);

    // Random traffic: fetch holds an instruction until it is taken
    pend = 1'b0; w = '0; pc = 64'h8000;
    for (int c = 0; c < 800; c++) begin
      if (!pend && ($urandom_range(0, 3) != 0)) begin
        w = $urandom;
        if ($urandom_range(0, 1) == 1) w[31:21] = 11'(pool[$urandom_range(0, 19)]);
        pc = pc + 64'd4;
        pend = 1'b1;
      end
      step(pend, w, pc, $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0, acc);
      if (acc) pend = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
